// File: rtl/sample_proc_seq_if.sv
// Control/handshake bundle between the DCFEB sample-readout sequencer and
// the data path it drives. The slave side belongs to the sequencer.
interface sample_proc_seq_if #(
    parameter int SEQ_W = 7,
    parameter int SMP_W = 7
);
    logic             L1A_BUF_MT;
    logic             FAMT;
    logic             L1A_HEAD;
    logic             TXACK;
    logic [SMP_W-1:0] SAMP_MAX;
    logic             ABORT;
    logic             CLR_TMO;
    logic             CE;
    logic             CLR_CRC;
    logic             LAST_WRD;
    logic             LD_HDR;
    logic [3:0]       HDR_IDX;
    logic             RD;
    logic             VALID;
    logic [SEQ_W-1:0] SEQ;
    logic [SMP_W-1:0] SMP;
    logic             ACK_TMO;
    logic             BUSY;
    logic [3:0]       SMP_STATE;

    modport slave (
        input  L1A_BUF_MT, FAMT, L1A_HEAD, TXACK, SAMP_MAX, ABORT, CLR_TMO,
        output CE, CLR_CRC, LAST_WRD, LD_HDR, HDR_IDX, RD, VALID, SEQ, SMP,
               ACK_TMO, BUSY, SMP_STATE
    );

    modport master (
        output L1A_BUF_MT, FAMT, L1A_HEAD, TXACK, SAMP_MAX, ABORT, CLR_TMO,
        input  CE, CLR_CRC, LAST_WRD, LD_HDR, HDR_IDX, RD, VALID, SEQ, SMP,
               ACK_TMO, BUSY, SMP_STATE
    );
endinterface

// File: rtl/sample_proc_seq.sv
// Sample-readout sequencer: streams one L1A event of ADC sample frames out of
// the sample FIFO (header load, pre-ack burst, TXACK handshake, per-sample
// data/tail/CRC words, end-of-event word). Outputs are registered from the
// next state so they line up with the cycle in which that state is current.
module sample_proc_seq #(
    parameter int SEQ_W          = 7,
    parameter int SMP_W          = 7,
    parameter int WORDS_PER_SAMP = 96,
    parameter int TAIL_WORDS     = 3,
    parameter int HDR_WORDS      = 2,
    parameter int PRE_ACK_WORDS  = 3,
    parameter int ACK_TO_W       = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    sample_proc_seq_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INC_SAMP  = 4'd1,
        LAST_WORD = 4'd2,
        LD_HDR    = 4'd3,
        READ      = 4'd5,
        ST_DATA   = 4'd6,
        STRT_SEQ  = 4'd7,
        TAIL      = 4'd8,
        W4DATA    = 4'd9,
        W4TXACK   = 4'd10
    } state_t;

    // SEQ all-ones means "no word on the bus"; it wraps to 0 on the first increment.
    localparam logic [SEQ_W-1:0]    SEQ_NONE      = {SEQ_W{1'b1}};
    localparam logic [SEQ_W-1:0]    SEQ_ZERO      = {SEQ_W{1'b0}};
    localparam logic [SEQ_W-1:0]    SEQ_ONE       = {{(SEQ_W-1){1'b0}}, 1'b1};
    localparam logic [SEQ_W-1:0]    SEQ_PRE_LAST  = SEQ_W'(PRE_ACK_WORDS - 1);
    localparam logic [SEQ_W-1:0]    SEQ_RD_LAST   = SEQ_W'(WORDS_PER_SAMP - 1);
    localparam logic [SEQ_W-1:0]    SEQ_TAIL_LAST = SEQ_W'(WORDS_PER_SAMP + TAIL_WORDS - 1);
    localparam logic [SMP_W-1:0]    SMP_ZERO      = {SMP_W{1'b0}};
    localparam logic [SMP_W-1:0]    SMP_ONE       = {{(SMP_W-1){1'b0}}, 1'b1};
    localparam logic [ACK_TO_W-1:0] TMO_ZERO      = {ACK_TO_W{1'b0}};
    localparam logic [ACK_TO_W-1:0] TMO_ONE       = {{(ACK_TO_W-1){1'b0}}, 1'b1};
    // Counter starts at 0 on entry, so hitting 2^N-2 marks the (2^N-1)th wait cycle.
    localparam logic [ACK_TO_W-1:0] TMO_LAST      = {{(ACK_TO_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]          HDR_LAST      = 4'((HDR_WORDS > 0) ? HDR_WORDS - 1 : 0);
    localparam bit                  HDR_EN        = (HDR_WORDS > 0);
    localparam bit                  TAIL_EN       = (TAIL_WORDS > 0);

    state_t              state_r, next_s;
    logic [SEQ_W-1:0]    seq_r, seq_s;
    logic [SMP_W-1:0]    smp_r, smp_s;
    logic [3:0]          hdr_idx_r, hdr_idx_s;
    logic [ACK_TO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [SMP_W-1:0]    samp_max_r;
    logic                abort_pend_r;
    logic                ack_tmo_r;
    logic                tmo_hit_s;
    state_t              post_rd_s, ack_dest_s;
    logic                ce_r, clr_crc_r, last_wrd_r, ld_hdr_r, rd_r, valid_r, busy_r;

    // Next-state decode from the current state and the registered counters.
    always_comb begin
        next_s     = IDLE;
        tmo_hit_s  = 1'b0;
        post_rd_s  = TAIL_EN ? TAIL : INC_SAMP;
        ack_dest_s = (seq_r == SEQ_RD_LAST) ? post_rd_s : READ;
        case (state_r)
            IDLE: begin
                if (!bus.L1A_BUF_MT) next_s = W4DATA;
                else                 next_s = IDLE;
            end
            W4DATA: begin
                if (bus.FAMT)                     next_s = W4DATA;
                else if (bus.L1A_HEAD && HDR_EN)  next_s = LD_HDR;
                else                              next_s = ST_DATA;
            end
            LD_HDR: begin
                if (hdr_idx_r == HDR_LAST) next_s = ST_DATA;
                else                       next_s = LD_HDR;
            end
            ST_DATA: begin
                if (bus.L1A_HEAD || (seq_r == SEQ_PRE_LAST)) next_s = W4TXACK;
                else                                         next_s = ST_DATA;
            end
            W4TXACK: begin
                // An acknowledge on the terminal-count cycle takes priority over the timeout.
                if (bus.TXACK) begin
                    next_s = ack_dest_s;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    next_s    = ack_dest_s;
                    tmo_hit_s = 1'b1;
                end else begin
                    next_s = W4TXACK;
                end
            end
            READ: begin
                if (seq_r == SEQ_RD_LAST) next_s = post_rd_s;
                else                      next_s = READ;
            end
            TAIL: begin
                if (seq_r == SEQ_TAIL_LAST) next_s = INC_SAMP;
                else                        next_s = TAIL;
            end
            INC_SAMP: begin
                if ((smp_r == samp_max_r) || abort_pend_r) next_s = LAST_WORD;
                else                                       next_s = STRT_SEQ;
            end
            STRT_SEQ:  next_s = READ;
            LAST_WORD: next_s = IDLE;
            default:   next_s = IDLE;
        endcase
    end

    // Word index, sample index, header index and timeout count for the state being entered.
    always_comb begin
        seq_s     = SEQ_NONE;
        smp_s     = smp_r;
        hdr_idx_s = 4'd0;
        tmo_cnt_s = TMO_ZERO;
        case (next_s)
            IDLE: smp_s = SMP_ZERO;
            LD_HDR: begin
                if (state_r == LD_HDR) hdr_idx_s = hdr_idx_r + 4'd1;
                else                   hdr_idx_s = 4'd0;
            end
            ST_DATA, READ, TAIL, INC_SAMP: seq_s = seq_r + SEQ_ONE;
            W4TXACK: begin
                seq_s = seq_r;
                if (state_r == W4TXACK) tmo_cnt_s = tmo_cnt_r + TMO_ONE;
                else                    tmo_cnt_s = TMO_ZERO;
            end
            STRT_SEQ: begin
                seq_s = SEQ_ZERO;
                smp_s = smp_r + SMP_ONE;
            end
            default: seq_s = SEQ_NONE;
        endcase
    end

    // State register plus registered outputs decoded from the state being entered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            seq_r      <= SEQ_NONE;
            smp_r      <= SMP_ZERO;
            hdr_idx_r  <= 4'd0;
            tmo_cnt_r  <= TMO_ZERO;
            ce_r       <= 1'b1;
            clr_crc_r  <= 1'b0;
            last_wrd_r <= 1'b0;
            ld_hdr_r   <= 1'b0;
            rd_r       <= 1'b0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_s;
            seq_r      <= seq_s;
            smp_r      <= smp_s;
            hdr_idx_r  <= hdr_idx_s;
            tmo_cnt_r  <= tmo_cnt_s;
            ce_r       <= (next_s != W4TXACK);
            clr_crc_r  <= (next_s == W4DATA) || (next_s == LD_HDR) || (next_s == INC_SAMP);
            last_wrd_r <= (next_s == LAST_WORD);
            ld_hdr_r   <= (next_s == LD_HDR);
            rd_r       <= (next_s == ST_DATA) || (next_s == READ) || (next_s == STRT_SEQ);
            valid_r    <= (next_s == ST_DATA) || (next_s == W4TXACK) || (next_s == READ) ||
                          (next_s == TAIL) || (next_s == INC_SAMP) || (next_s == STRT_SEQ);
            busy_r     <= (next_s != IDLE);
        end
    end

    // Event-scoped latches: sample count, pending abort, and the sticky TXACK timeout flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            samp_max_r   <= SMP_ZERO;
            abort_pend_r <= 1'b0;
            ack_tmo_r    <= 1'b0;
        end else begin
            if ((state_r == IDLE) && !bus.L1A_BUF_MT) samp_max_r <= bus.SAMP_MAX;
            else                                      samp_max_r <= samp_max_r;
            if (state_r == LAST_WORD)                      abort_pend_r <= 1'b0;
            else if (bus.ABORT && (state_r != IDLE))       abort_pend_r <= 1'b1;
            else                                           abort_pend_r <= abort_pend_r;
            // A new timeout wins over a simultaneous clear.
            if (tmo_hit_s)        ack_tmo_r <= 1'b1;
            else if (bus.CLR_TMO) ack_tmo_r <= 1'b0;
            else                  ack_tmo_r <= ack_tmo_r;
        end
    end

    assign bus.CE        = ce_r;
    assign bus.CLR_CRC   = clr_crc_r;
    assign bus.LAST_WRD  = last_wrd_r;
    assign bus.LD_HDR    = ld_hdr_r;
    assign bus.HDR_IDX   = hdr_idx_r;
    assign bus.RD        = rd_r;
    assign bus.VALID     = valid_r;
    assign bus.SEQ       = seq_r;
    assign bus.SMP       = smp_r;
    assign bus.ACK_TMO   = ack_tmo_r;
    assign bus.BUSY      = busy_r;
    assign bus.SMP_STATE = state_r;

endmodule

// File: tb/tb_sample_proc_seq.sv
// Directed bench for sample_proc_seq: cycle tables for the start of an event,
// plus hand-written sequences for full events, timeout, abort, reset and FIFO stall.
module tb_sample_proc_seq;
    localparam logic [3:0] S_IDLE = 4'd0, S_INC = 4'd1, S_HDR = 4'd3, S_READ = 4'd5,
                           S_STD = 4'd6, S_STRT = 4'd7, S_TAIL = 4'd8, S_W4D = 4'd9,
                           S_W4A = 4'd10;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    sample_proc_seq_if #(.SEQ_W(7), .SMP_W(7)) bus ();
    sample_proc_seq_if #(.SEQ_W(7), .SMP_W(7)) bus2 ();

    sample_proc_seq #(.SEQ_W(7), .SMP_W(7), .WORDS_PER_SAMP(96), .TAIL_WORDS(3),
                      .HDR_WORDS(2), .PRE_ACK_WORDS(3), .ACK_TO_W(4))
        dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    sample_proc_seq #(.SEQ_W(7), .SMP_W(7), .WORDS_PER_SAMP(8), .TAIL_WORDS(1),
                      .HDR_WORDS(2), .PRE_ACK_WORDS(3), .ACK_TO_W(4))
        dut_small (.CLK(CLK), .RST_N(RST_N), .bus(bus2));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic       busy;
        logic       ce;
        logic       clr_crc;
        logic       ld_hdr;
        logic [3:0] hdr_idx;
        logic       rd;
        logic       valid;
        logic [6:0] seq;
        logic [6:0] smp;
        logic       last_wrd;
        logic       ack_tmo;
    } outs_t;

    typedef struct {
        int    buf_mt;
        int    famt;
        int    head;
        int    txack;
        int    smax;
        outs_t exp;
    } vec_t;

    vec_t tq[$];

    function automatic outs_t mk_outs(input int st, input int ce, input int clr, input int ld,
                                      input int idx, input int rd, input int v, input int seq,
                                      input int smp, input int lw, input int tmo);
        outs_t o;
        o.st = 4'(st); o.busy = (st != 0); o.ce = 1'(ce); o.clr_crc = 1'(clr);
        o.ld_hdr = 1'(ld); o.hdr_idx = 4'(idx); o.rd = 1'(rd); o.valid = 1'(v);
        o.seq = 7'(seq); o.smp = 7'(smp); o.last_wrd = 1'(lw); o.ack_tmo = 1'(tmo);
        return o;
    endfunction

    function automatic outs_t get_outs();
        outs_t o;
        o.st = bus.SMP_STATE; o.busy = bus.BUSY; o.ce = bus.CE; o.clr_crc = bus.CLR_CRC;
        o.ld_hdr = bus.LD_HDR; o.hdr_idx = bus.HDR_IDX; o.rd = bus.RD; o.valid = bus.VALID;
        o.seq = bus.SEQ; o.smp = bus.SMP; o.last_wrd = bus.LAST_WRD; o.ack_tmo = bus.ACK_TMO;
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input outs_t act, input outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%0d busy=%b ce=%b clr=%b ld=%b idx=%0d rd=%b v=%b seq=%0d smp=%0d lw=%b tmo=%b expected st=%0d busy=%b ce=%b clr=%b ld=%b idx=%0d rd=%b v=%b seq=%0d smp=%0d lw=%b tmo=%b",
                     nm, act.st, act.busy, act.ce, act.clr_crc, act.ld_hdr, act.hdr_idx, act.rd,
                     act.valid, act.seq, act.smp, act.last_wrd, act.ack_tmo,
                     exp.st, exp.busy, exp.ce, exp.clr_crc, exp.ld_hdr, exp.hdr_idx, exp.rd,
                     exp.valid, exp.seq, exp.smp, exp.last_wrd, exp.ack_tmo);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic add_vec(input int buf_mt, input int famt, input int head, input int txack,
                           input int smax, input outs_t exp);
        vec_t v;
        v.buf_mt = buf_mt; v.famt = famt; v.head = head; v.txack = txack; v.smax = smax;
        v.exp = exp;
        tq.push_back(v);
    endtask

    task automatic apply_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.L1A_BUF_MT = 1'(tq[i].buf_mt);
            bus.FAMT       = 1'(tq[i].famt);
            bus.L1A_HEAD   = 1'(tq[i].head);
            bus.TXACK      = 1'(tq[i].txack);
            bus.SAMP_MAX   = 7'(tq[i].smax);
            tick();
            chk_outs($sformatf("vec%0d", i), get_outs(), tq[i].exp);
        end
    endtask

    // Starts an event from IDLE; returns with the DUT in W4DATA and the buffer marked empty.
    task automatic start_event(input int smax, input int head, input int txack, input int famt);
        bus.L1A_BUF_MT = 1'b0; bus.FAMT = 1'(famt); bus.L1A_HEAD = 1'(head);
        bus.TXACK = 1'(txack); bus.SAMP_MAX = 7'(smax);
        tick();
        bus.L1A_BUF_MT = 1'b1;
    endtask

    // Runs the current event to LAST_WRD, counting strobes, then checks the return to IDLE.
    task automatic run_event(input string nm, input int abort_smp, input int chg_max,
                             input int exp_rd, input int exp_inc, input int exp_max_smp,
                             input int exp_tmo);
        int rd_n = 0, inc_n = 0, lw_n = 0, max_smp = 0;
        bit ab_done = 1'b0, done = 1'b0;
        for (int c = 0; c < 1500 && !done; c++) begin
            bus.ABORT = 1'b0;
            if (abort_smp >= 0 && !ab_done && bus.SMP_STATE == S_READ &&
                int'(bus.SMP) == abort_smp && bus.SEQ == 7'd40) begin
                bus.ABORT = 1'b1;
                ab_done   = 1'b1;
            end
            if (chg_max >= 0 && bus.SMP_STATE == S_READ) bus.SAMP_MAX = 7'(chg_max);
            tick();
            if (bus.RD) rd_n++;
            if (bus.SMP_STATE == S_INC) begin
                inc_n++;
                chk({nm, "_inc_seq"}, int'(bus.SEQ), 99);
            end
            if (bus.SMP_STATE == S_STRT) chk({nm, "_strt_seq"}, int'(bus.SEQ), 0);
            if (int'(bus.SMP) > max_smp) max_smp = int'(bus.SMP);
            if (bus.LAST_WRD) begin
                lw_n++;
                done = 1'b1;
            end
        end
        bus.ABORT = 1'b0;
        chk({nm, "_reached_end"}, int'(done), 1);
        chk({nm, "_rd_count"}, rd_n, exp_rd);
        chk({nm, "_inc_count"}, inc_n, exp_inc);
        chk({nm, "_max_smp"}, max_smp, exp_max_smp);
        chk({nm, "_last_wrd"}, lw_n, 1);
        tick();
        chk_outs({nm, "_idle"}, get_outs(), mk_outs(0, 1, 0, 0, 0, 0, 0, 127, 0, 0, exp_tmo));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_w4a, rd2, tail_seq, inc_seq;
        bit found, lw_seen, done2;
        outs_t rst_v;

        // Event A: no header, TXACK high, two samples.
        add_vec(0, 0, 0, 1, 1, mk_outs(S_W4D, 1, 1, 0, 0, 0, 0, 127, 0, 0, 0));
        add_vec(1, 0, 0, 1, 1, mk_outs(S_STD, 1, 0, 0, 0, 1, 1,   0, 0, 0, 0));
        add_vec(1, 0, 0, 1, 1, mk_outs(S_STD, 1, 0, 0, 0, 1, 1,   1, 0, 0, 0));
        add_vec(1, 0, 0, 1, 1, mk_outs(S_STD, 1, 0, 0, 0, 1, 1,   2, 0, 0, 0));
        add_vec(1, 0, 0, 1, 1, mk_outs(S_W4A, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0));
        add_vec(1, 0, 0, 1, 1, mk_outs(S_READ, 1, 0, 0, 0, 1, 1,  3, 0, 0, 0));
        // Event B: header present, one sample.
        add_vec(0, 1, 1, 0, 0, mk_outs(S_W4D, 1, 1, 0, 0, 0, 0, 127, 0, 0, 0));
        add_vec(1, 1, 1, 0, 0, mk_outs(S_W4D, 1, 1, 0, 0, 0, 0, 127, 0, 0, 0));
        add_vec(1, 0, 1, 0, 0, mk_outs(S_HDR, 1, 1, 1, 0, 0, 0, 127, 0, 0, 0));
        add_vec(1, 0, 1, 0, 0, mk_outs(S_HDR, 1, 1, 1, 1, 0, 0, 127, 0, 0, 0));
        add_vec(1, 0, 1, 0, 0, mk_outs(S_STD, 1, 0, 0, 0, 1, 1,   0, 0, 0, 0));
        add_vec(1, 0, 1, 0, 0, mk_outs(S_W4A, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0));
        add_vec(1, 0, 1, 1, 0, mk_outs(S_READ, 1, 0, 0, 0, 1, 1,  1, 0, 0, 0));
        add_vec(1, 0, 1, 0, 0, mk_outs(S_READ, 1, 0, 0, 0, 1, 1,  2, 0, 0, 0));

        rst_v = mk_outs(0, 1, 0, 0, 0, 0, 0, 127, 0, 0, 0);
        bus.L1A_BUF_MT = 1'b1; bus.FAMT = 1'b1; bus.L1A_HEAD = 1'b0; bus.TXACK = 1'b0;
        bus.SAMP_MAX = 7'd0; bus.ABORT = 1'b0; bus.CLR_TMO = 1'b0;
        bus2.L1A_BUF_MT = 1'b1; bus2.FAMT = 1'b1; bus2.L1A_HEAD = 1'b0; bus2.TXACK = 1'b0;
        bus2.SAMP_MAX = 7'd0; bus2.ABORT = 1'b0; bus2.CLR_TMO = 1'b0;
        RST_N = 1'b0;
        tick();
        tick();
        chk_outs("reset_state", get_outs(), rst_v);
        RST_N = 1'b1;
        tick();
        chk_outs("idle_after_reset", get_outs(), rst_v);

        apply_vecs(0, 5);
        run_event("evtA", -1, -1, 188, 2, 1, 0);

        apply_vecs(6, 13);
        bus.L1A_HEAD = 1'b0;
        run_event("evtB", -1, -1, 93, 1, 0, 0);

        // TXACK held low: 15 wait cycles, sticky timeout flag, then READ anyway.
        start_event(0, 0, 0, 0);
        repeat (4) tick();
        n_w4a = 0;
        while (bus.SMP_STATE == S_W4A && n_w4a < 40) begin
            if (bus.CE !== 1'b0) chk("tmo_ce_low", int'(bus.CE), 0);
            n_w4a++;
            tick();
        end
        chk("tmo_wait_cycles", n_w4a, 15);
        chk_outs("tmo_read", get_outs(), mk_outs(S_READ, 1, 0, 0, 0, 1, 1, 3, 0, 0, 1));
        run_event("evtC", -1, -1, 92, 1, 0, 1);

        // Abort during sample 1 of a 6-sample event; SAMP_MAX change mid-event is ignored.
        start_event(5, 0, 1, 0);
        chk("tmo_sticky", int'(bus.ACK_TMO), 1);
        run_event("evtD", 1, 0, 192, 2, 1, 1);

        bus.CLR_TMO = 1'b1;
        tick();
        bus.CLR_TMO = 1'b0;
        chk("tmo_cleared", int'(bus.ACK_TMO), 0);

        // TXACK arriving on the terminal-count cycle counts as an acknowledge.
        start_event(0, 0, 0, 0);
        repeat (4) tick();
        for (int k = 1; k < 15; k++) tick();
        chk("tc_still_waiting", int'(bus.SMP_STATE), int'(S_W4A));
        bus.TXACK = 1'b1;
        tick();
        chk_outs("tc_ack", get_outs(), mk_outs(S_READ, 1, 0, 0, 0, 1, 1, 3, 0, 0, 0));
        run_event("evtE", -1, -1, 92, 1, 0, 0);

        // FIFO almost empty for 20 cycles holds W4DATA with CLR_CRC and no reads.
        start_event(0, 0, 1, 1);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            chk($sformatf("famt_hold%0d", k),
                int'({bus.SMP_STATE, bus.CLR_CRC, bus.RD}), int'({S_W4D, 1'b1, 1'b0}));
        end
        bus.FAMT = 1'b0;
        run_event("evtF", -1, -1, 96, 1, 0, 0);

        // Asynchronous reset in the middle of READ.
        start_event(0, 0, 1, 0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (bus.SMP_STATE == S_READ && bus.SEQ == 7'd40) found = 1'b1;
        end
        chk("reach_seq40", int'(found), 1);
        #2 RST_N = 1'b0;
        #1 chk_outs("async_reset", get_outs(), rst_v);
        tick();
        RST_N = 1'b1;
        lw_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.LAST_WRD) lw_seen = 1'b1;
        end
        chk("no_lw_after_reset", int'(lw_seen), 0);
        chk_outs("idle_after_release", get_outs(), rst_v);

        // Small-frame instance: 8 data words, 1 tail word.
        bus2.L1A_BUF_MT = 1'b0; bus2.FAMT = 1'b0; bus2.TXACK = 1'b1; bus2.SAMP_MAX = 7'd0;
        tick();
        bus2.L1A_BUF_MT = 1'b1;
        rd2 = 0; tail_seq = -1; inc_seq = -1; done2 = 1'b0;
        for (int k = 0; k < 60 && !done2; k++) begin
            tick();
            if (bus2.RD) rd2++;
            if (bus2.SMP_STATE == S_TAIL && tail_seq < 0) tail_seq = int'(bus2.SEQ);
            if (bus2.SMP_STATE == S_INC) inc_seq = int'(bus2.SEQ);
            if (bus2.LAST_WRD) done2 = 1'b1;
        end
        chk("small_done", int'(done2), 1);
        chk("small_tail_seq", tail_seq, 8);
        chk("small_inc_seq", inc_seq, 9);
        chk("small_rd_count", rd2, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_proc_seq.md
Name: sample_proc_seq

Overview:
- Parametrised sample-readout sequencer for the DCFEB data path.
- Sequences one L1A event's worth of ADC sample frames out of the sample FIFO: optional L1A header words, a pre-acknowledge burst, the link TXACK handshake, then per-sample read, tail and CRC words, then an end-of-event word.
- Generalises the fixed 96+3 word, 2-header-word sequencer: words per sample, tail, header and pre-ack lengths are parameters.
- New features: latched sample count, TXACK timeout with a sticky error flag, and a graceful ABORT.

Parameters:
- SEQ_W, 7: width of SEQ; all-ones is reserved as the "no word" value.
- SMP_W, 7: width of SAMP_MAX and SMP.
- WORDS_PER_SAMP, 96: data words per sample frame.
- TAIL_WORDS, 3: tail words per sample, not read from the FIFO.
- HDR_WORDS, 2: L1A header load cycles; 0 disables header loading.
- PRE_ACK_WORDS, 3: words read before TXACK when there is no header.
- ACK_TO_W, 10: TXACK timeout counter width; timeout is 2^ACK_TO_W-1 cycles.
- Legal ranges: 1<=PRE_ACK_WORDS<=WORDS_PER_SAMP; WORDS_PER_SAMP+TAIL_WORDS+1 < 2^SEQ_W; HDR_WORDS<=16.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- L1A_BUF_MT  in  1  L1A buffer empty.
- FAMT  in  1  sample FIFO almost empty.
- L1A_HEAD  in  1  event carries an L1A header.
- TXACK  in  1  link transmitter acknowledge.
- SAMP_MAX  in  SMP_W  number of samples minus 1; latched at event start.
- ABORT  in  1  single-cycle request to end the event early.
- CLR_TMO  in  1  clears ACK_TMO.
- CE  out  1  data-path clock enable.
- CLR_CRC  out  1  clear CRC accumulator.
- LAST_WRD  out  1  end-of-event word strobe.
- LD_HDR  out  1  load one header word.
- HDR_IDX  out  4  index of the header word being loaded.
- RD  out  1  sample FIFO read strobe.
- VALID  out  1  output word valid.
- SEQ  out  SEQ_W  word index within the sample.
- SMP  out  SMP_W  current sample index.
- ACK_TMO  out  1  sticky TXACK-timeout flag.
- BUSY  out  1  high whenever state is not IDLE.
- SMP_STATE  out  4  state encoding, for debug.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; CE=1; SEQ=all-ones; SMP=0.
  - CLR_CRC, LAST_WRD, LD_HDR, RD, VALID, ACK_TMO, BUSY all 0; HDR_IDX=0.
  - Reset mid-event abandons the event; there is no LAST_WRD.
- Output timing:
  - Outputs are registered and decoded from nextstate, so they are valid in the same cycle the state is current.
  - Defaults every cycle: CE=1, strobes=0, SEQ=all-ones, SMP holds.
- State encodings: IDLE 0, INC_SAMP 1, LAST_WORD 2, LD_HDR 3, READ 5, ST_DATA 6, STRT_SEQ 7, TAIL 8, W4DATA 9, W4TXACK 10. Any other value goes to IDLE on the next clock.
- IDLE: SMP=0. If !L1A_BUF_MT, latch SAMP_MAX and go to W4DATA.
- W4DATA: CLR_CRC=1. Waits while FAMT=1. On !FAMT:
  - L1A_HEAD && HDR_WORDS>0: go to LD_HDR.
  - otherwise: go to ST_DATA.
- LD_HDR: CLR_CRC=1, LD_HDR=1, HDR_IDX counts 0..HDR_WORDS-1 (one per cycle), then go to ST_DATA.
- ST_DATA: RD=1, VALID=1, SEQ=SEQ+1, wrapping all-ones to 0.
  - Go to W4TXACK if L1A_HEAD, or if SEQ==PRE_ACK_WORDS-1.
- W4TXACK: CE=0, VALID=1, SEQ holds. Timeout counter clears on entry.
  - TXACK=1: go to READ.
  - Counter reaches 2^ACK_TO_W-1 with TXACK=0: set ACK_TMO=1 and go to READ anyway.
  - TXACK on the terminal-count cycle: treat as an acknowledge; ACK_TMO is not set.
- READ: RD=1, VALID=1, SEQ=SEQ+1. When SEQ==WORDS_PER_SAMP-1, go to TAIL.
- TAIL: VALID=1, SEQ=SEQ+1. When SEQ==WORDS_PER_SAMP+TAIL_WORDS-1, go to INC_SAMP.
- INC_SAMP: CLR_CRC=1, VALID=1, SEQ=SEQ+1.
  - Go to LAST_WORD if SMP==latched SAMP_MAX or an abort is pending.
  - Otherwise go to STRT_SEQ.
- STRT_SEQ: RD=1, VALID=1, SEQ=0, SMP=SMP+1, then go to READ.
- LAST_WORD: LAST_WRD=1, clear the abort-pending flag, go to IDLE.
- ABORT:
  - Sampled in any non-IDLE state into a pending flag; ignored in IDLE.
  - Takes effect only at the next INC_SAMP, so the current sample always completes.
  - ABORT together with the final sample behaves as a normal end.
- SAMP_MAX changes after latching are ignored until the next event. SAMP_MAX=0 gives exactly one sample.
- ACK_TMO clears only on reset or CLR_TMO. If CLR_TMO and a new timeout occur in the same cycle, the set wins.
- SMP increments without saturation; the latched SAMP_MAX bounds it.

Test Plan:
- Defaults, L1A_HEAD=0, TXACK=1, SAMP_MAX=1, FIFO non-empty:
  - ST_DATA SEQ 0,1,2 → one W4TXACK cycle with CE=0 → READ SEQ 3..95 → TAIL 96..98 → INC_SAMP SEQ 99.
  - STRT_SEQ SEQ=0, SMP=1 → READ 1..95 → TAIL → INC_SAMP → LAST_WORD → IDLE.
  - Totals: 192 RD pulses, 2 INC_SAMP, 1 LAST_WRD.
- L1A_HEAD=1, HDR_WORDS=2 → LD_HDR with HDR_IDX 0 then 1 (CLR_CRC=1 both cycles) → ST_DATA one cycle SEQ=0 → W4TXACK.
- TXACK held 0 with ACK_TO_W=4 → W4TXACK lasts 15 cycles → ACK_TMO=1 → READ. ACK_TMO stays set through the next event; CLR_TMO pulse clears it.
- SAMP_MAX=5, ABORT pulse during sample 1 READ → sample 1 completes → INC_SAMP → LAST_WORD, SMP never reaches 2. SAMP_MAX changed mid-event has no effect.
- RST_N low during READ (SEQ=40) → all outputs at reset values immediately, with no clock edge. After release with L1A_BUF_MT=1, stays in IDLE.
- FAMT=1 for 20 cycles in W4DATA → holds with CLR_CRC=1, RD=0. Parameter set WORDS_PER_SAMP=8, TAIL_WORDS=1 → TAIL at SEQ 8, INC_SAMP at SEQ 9.
